// File: rtl/fir_pkg.sv
// fir_pkg: definitions shared by the folded symmetric FIR and its downstream
// decimator/FIFO stage.
//   FRAC_BITS            fractional bits of the Q8.8 sample format
//   DEFAULT_DATA_WIDTH   sample width used by the FIR data_out
//   DEFAULT_DECIM        default decimation ratio
//   fir_sample_t         signed Q8.8 sample type
package fir_pkg;

  localparam int FRAC_BITS          = 8;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DECIM      = 4;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] fir_sample_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with a registered show-ahead head.
//   clk, reset   clock, synchronous active-high reset
//   wr_data      signed sample written when push=1
//   push         write request (already qualified by the caller)
//   pop          read request (caller guarantees out_valid=1)
//   out_data     registered head entry; holds its last value while out_valid=0
//   out_valid    registered "head is valid"
//   level        occupancy, 0..FIFO_DEPTH
//   full, empty  level == FIFO_DEPTH / level == 0
module sync_fifo
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  wr_data,
  input  logic                          push,
  input  logic                          pop,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic [AW-1:0]                rd_ptr_nxt;
  logic [LW-1:0]                level_after_pop;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);

  // The head register is refreshed from the state left by the previous edge
  // minus this edge's pop; an entry written on this same edge is not visible
  // yet, so a sample always reaches out_data one cycle after it is pushed.
  assign rd_ptr_nxt      = rd_ptr + AW'(pop);
  assign level_after_pop = level - LW'(pop);

  // Storage is data only and needs no reset. When full with a simultaneous
  // pop, wr_ptr equals rd_ptr: the slot being overwritten is the one leaving.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr_nxt;
      level     <= level + LW'(push) - LW'(pop);
      out_valid <= (level_after_pop != '0);
      if (level_after_pop != '0) out_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/fir_decimator_fifo.sv
// fir_decimator_fifo: drops the FIR warm-up samples, keeps 1 of every DECIM
// strobed samples, buffers them in sync_fifo and hands them out over
// valid/ready. Kept samples arriving while the FIFO is full are dropped and
// raise a sticky overflow flag.
//   clk, reset       clock, synchronous active-high reset
//   in_sample        signed Q8.8 FIR output sample
//   in_strobe        in_sample is new this cycle
//   out_data         signed sample at the FIFO head (registered)
//   out_valid        out_data valid (registered)
//   out_ready        consumer accepts out_data this cycle
//   fifo_level       FIFO occupancy 0..FIFO_DEPTH
//   overflow         sticky drop flag
//   clear_overflow   clears overflow (a drop in the same cycle wins)
module fir_decimator_fifo
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DECIM      = DEFAULT_DECIM,
  parameter int FIFO_DEPTH = 8,
  parameter int WARMUP     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  in_sample,
  input  logic                          in_strobe,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  // Widths are kept at least 1 bit so WARMUP=0 and DECIM=1 stay legal.
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW = (DECIM > 1)  ? $clog2(DECIM)      : 1;

  logic [WW-1:0] warm_cnt;
  logic [PW-1:0] phase;
  logic          warm_done;
  logic          live;
  logic          keep;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;
  logic          empty;

  assign warm_done = (warm_cnt == WW'(WARMUP));
  assign live      = in_strobe && warm_done;
  assign keep      = live && (phase == '0);
  // out_valid already implies a non-empty FIFO; the empty guard makes it
  // impossible for the level to wrap below zero.
  assign pop       = out_valid && out_ready && !empty;
  assign push      = keep && (!full || pop);
  assign drop      = keep && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_strobe && !warm_done) warm_cnt <= warm_cnt + 1'b1;
      // Phase advances on every post-warm-up strobe, including dropped ones.
      if (live) phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (in_sample),
    .push      (push),
    .pop       (pop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .level     (fifo_level),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_fir_decimator_fifo.sv
module tb_fir_decimator_fifo;
  import fir_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  fir_sample_t in_sample;
  logic        in_strobe;
  fir_sample_t out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        clear_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_decimator_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .in_sample      (in_sample),
    .in_strobe      (in_strobe),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic step(input logic s, input logic [15:0] d, input logic r, input logic c);
    in_strobe      = s;
    in_sample      = d;
    out_ready      = r;
    clear_overflow = c;
    @(posedge clk); #1;
    in_strobe      = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_sample = '0; in_strobe = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 0);
    check_val("rst_level", 16'(fifo_level), 16'd0);
    check_val("rst_valid", 16'(out_valid), 16'd0);
    check_val("rst_data", out_data, 16'h0000);
    check_val("rst_ovf", 16'(overflow), 16'd0);
    reset = 1'b0;

    // Warm-up: 8 strobes discarded.
    for (int i = 0; i < 8; i++) begin
      step(1, 16'h0100, 1, 0);
      check_val("warm_level", 16'(fifo_level), 16'd0);
      check_val("warm_valid", 16'(out_valid), 16'd0);
    end

    // Ramp 1..16 with out_ready=1: 1,5,9,13 each valid for one cycle,
    // one cycle after its push.
    for (int k = 1; k <= 16; k++) begin
      step(1, 16'(k), 1, 0);
      if (k >= 2 && ((k - 2) % 4) == 0) begin
        check_val("ramp_valid", 16'(out_valid), 16'd1);
        check_val("ramp_data", out_data, 16'(k - 1));
      end else begin
        check_val("ramp_idle", 16'(out_valid), 16'd0);
      end
    end
    check_val("ramp_level", 16'(fifo_level), 16'd0);

    // Back-pressure: 40 strobes, 10 kept, last 2 dropped. Head holds steady.
    for (int k = 0; k < 40; k++) begin
      step(1, 16'hF000 + 16'(k), 0, 0);
      if (k >= 1) begin
        check_val("hold_valid", 16'(out_valid), 16'd1);
        check_val("hold_data", out_data, 16'hF000);
      end
    end
    check_val("bp_level", 16'(fifo_level), 16'd8);
    check_val("bp_ovf", 16'(overflow), 16'd1);
    for (int i = 0; i < 8; i++) begin
      check_val("drain_valid", 16'(out_valid), 16'd1);
      check_val("drain_data", out_data, 16'hF000 + 16'(4 * i));
      step(0, 16'h0000, 1, 0);
    end
    check_val("drain_level", 16'(fifo_level), 16'd0);
    check_val("drain_valid_end", 16'(out_valid), 16'd0);
    step(0, 16'h0000, 0, 1);
    check_val("clr_ovf", 16'(overflow), 16'd0);

    // Refill to full: 29 strobes keep 8 samples, phase ends at 1.
    for (int k = 0; k < 29; k++) step(1, 16'h0200 + 16'(k), 0, 0);
    check_val("full_level", 16'(fifo_level), 16'd8);
    check_val("full_head", out_data, 16'h0200);
    for (int k = 0; k < 3; k++) step(1, 16'h0300, 0, 0);
    // Kept sample at full with simultaneous pop: accepted, level unchanged.
    step(1, 16'h7FFF, 1, 0);
    check_val("pp_level", 16'(fifo_level), 16'd8);
    check_val("pp_ovf", 16'(overflow), 16'd0);
    check_val("pp_head", out_data, 16'h0204);

    // Drop sets overflow; drop with clear in the same cycle keeps it set.
    for (int k = 0; k < 3; k++) step(1, 16'h0300, 0, 0);
    step(1, 16'h1111, 0, 0);
    check_val("drop_ovf", 16'(overflow), 16'd1);
    for (int k = 0; k < 3; k++) step(1, 16'h0300, 0, 0);
    step(1, 16'h2222, 0, 1);
    check_val("drop_clr_ovf", 16'(overflow), 16'd1);
    check_val("drop_level", 16'(fifo_level), 16'd8);
    step(0, 16'h0000, 0, 1);
    check_val("clr_alone_ovf", 16'(overflow), 16'd0);

    // Pop 3 to reach level 5, then reset mid-stream.
    for (int i = 0; i < 3; i++) step(0, 16'h0000, 1, 0);
    check_val("pre_rst_level", 16'(fifo_level), 16'd5);
    check_val("pre_rst_head", out_data, 16'h0210);
    reset = 1'b1;
    step(1, 16'h0400, 1, 0);
    reset = 1'b0;
    check_val("mid_rst_level", 16'(fifo_level), 16'd0);
    check_val("mid_rst_valid", 16'(out_valid), 16'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 16'h0500, 0, 0);
      check_val("rewarm_level", 16'(fifo_level), 16'd0);
    end
    step(1, 16'h8001, 0, 0);
    check_val("post_warm_level", 16'(fifo_level), 16'd1);
    check_val("post_warm_valid", 16'(out_valid), 16'd0);
    step(0, 16'h0000, 0, 0);
    check_val("post_warm_valid2", 16'(out_valid), 16'd1);
    check_val("post_warm_data", out_data, 16'h8001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
